// File: rtl/hash_avalon_frontend.sv
// Avalon-MM register front end for a block hash core.
// Software writes message words into a block buffer through the DATA register,
// closes a message with CTRL.LAST, and reads the digest back once the core
// returns it. Build option: define HASH_FRONTEND_IRQ_EN to add an irq output
// raised when a digest becomes available (mirrored in STATUS bit 4).
module hash_avalon_frontend #(
    parameter int BLOCK_WORDS  = 16,
    parameter int DIGEST_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [3:0]                address,
    input  logic [31:0]               writedata,
    input  logic [3:0]                byteenable,
    input  logic                      write,
    input  logic                      read,
    input  logic                      chipselect,
    output logic [31:0]               readdata,
    output logic [32*BLOCK_WORDS-1:0] blk_data,
    output logic                      blk_last,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    input  logic [32*DIGEST_WORDS-1:0] dig_data,
    input  logic                      dig_valid
`ifdef HASH_FRONTEND_IRQ_EN
    ,
    output logic                      irq
`endif
);

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_DIG = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BLOCK_WORDS - 1);
    localparam logic [7:0] FULL_CNT = 8'(BLOCK_WORDS);

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        blk_last_q, blk_last_d;
    logic        ovf_q, ovf_d;
    logic [31:0] readdata_q;
    logic [31:0] buf_q [BLOCK_WORDS];
    logic [31:0] digest_q [DIGEST_WORDS];
    logic [31:0] dig_pad [8];

    logic        wr_acc, rd_acc, data_wr, ctrl_wr, clear_req;
    logic        buf_wr, buf_clr, dig_cap;
    logic [31:0] wdata_masked;
    logic [31:0] status_word;
    logic [31:0] rd_data;
    logic        irq_bit;

    assign wr_acc    = chipselect & write;
    assign rd_acc    = chipselect & read;
    assign data_wr   = wr_acc && (address == 4'h8);
    assign ctrl_wr   = wr_acc && (address == 4'h9);
    assign clear_req = ctrl_wr && writedata[1];

    // Disabled byte lanes are stored as zero rather than left unchanged.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_masked[8*gi +: 8] = byteenable[gi] ? writedata[8*gi +: 8] : 8'h00;
    end

    // Next-state logic: buffer fill, block issue, digest wait; CLEAR overrides all.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        blk_last_d = blk_last_q;
        ovf_d      = ovf_q;
        buf_wr     = 1'b0;
        buf_clr    = 1'b0;
        dig_cap    = 1'b0;
        case (state_q)
            S_FILL: begin
                if (data_wr) begin
                    buf_wr  = 1'b1;
                    count_d = count_q + 8'd1;
                    if (count_q == LAST_IDX) begin
                        state_d    = S_ISSUE;
                        blk_last_d = 1'b0;
                    end
                end else if (ctrl_wr && writedata[0]) begin
                    state_d    = S_ISSUE;
                    blk_last_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (data_wr) ovf_d = 1'b1;
                if (blk_ready) begin
                    buf_clr = 1'b1;
                    count_d = 8'd0;
                    state_d = blk_last_q ? S_WAIT_DIG : S_FILL;
                end
            end
            S_WAIT_DIG: begin
                if (data_wr) ovf_d = 1'b1;
                if (dig_valid) begin
                    dig_cap = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // count is zero here (cleared at handshake), so this lands in word 0
                if (data_wr) begin
                    buf_wr  = 1'b1;
                    count_d = count_q + 8'd1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
        if (clear_req) begin
            state_d    = S_FILL;
            count_d    = 8'd0;
            blk_last_d = 1'b0;
            ovf_d      = 1'b0;
            buf_wr     = 1'b0;
            buf_clr    = 1'b1;
            dig_cap    = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FILL;
            count_q    <= 8'd0;
            blk_last_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            blk_last_q <= blk_last_d;
            ovf_q      <= ovf_d;
        end
    end

    // Block buffer, one register per word, written at the current fill index.
    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_buf
        localparam logic [7:0] IDX = 8'(gi);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                buf_q[gi] <= 32'd0;
            end else if (buf_clr) begin
                buf_q[gi] <= 32'd0;
            end else if (buf_wr && (count_q == IDX)) begin
                buf_q[gi] <= wdata_masked;
            end
        end
        assign blk_data[32*gi +: 32] = buf_q[gi];
    end

    // Digest capture registers, loaded only on the strobe accepted in WAIT_DIG.
    for (genvar gi = 0; gi < DIGEST_WORDS; gi++) begin : g_dig
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                digest_q[gi] <= 32'd0;
            end else if (dig_cap) begin
                digest_q[gi] <= dig_data[32*gi +: 32];
            end
        end
    end

    // Digest window is always eight words wide; missing words read as zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
        if (gi < DIGEST_WORDS) begin : g_real
            assign dig_pad[gi] = digest_q[gi];
        end else begin : g_zero
            assign dig_pad[gi] = 32'd0;
        end
    end

`ifdef HASH_FRONTEND_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt: raised on entry to DONE, cleared by a STATUS read or CLEAR.
    always_comb begin
        irq_d = irq_q;
        if (rd_acc && (address == 4'hA)) irq_d = 1'b0;
        if ((state_q != S_DONE) && (state_d == S_DONE)) irq_d = 1'b1;
        if (clear_req) irq_d = 1'b0;
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    assign irq_bit = 1'b0;
`endif

    assign status_word = {16'b0, count_q, 3'b0, irq_bit, ovf_q,
                          (count_q == FULL_CNT), (state_q == S_DONE),
                          ((state_q == S_ISSUE) || (state_q == S_WAIT_DIG))};

    // Register-map read decode.
    always_comb begin
        rd_data = 32'd0;
        if (address[3] == 1'b0) begin
            rd_data = dig_pad[address[2:0]];
        end else if (address == 4'hA) begin
            rd_data = status_word;
        end
    end

    // Read data register: loads on a read access, holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    readdata_q <= 32'd0;
        else if (rd_acc) readdata_q <= rd_data;
    end

    assign readdata  = readdata_q;
    assign blk_valid = (state_q == S_ISSUE);
    assign blk_last  = blk_last_q;

endmodule

// File: doc/hash_avalon_frontend.md
HASH_AVALON_FRONTEND -- requirements
Module: hash_avalon_frontend

Interface
REQ-001 Parameter BLOCK_WORDS, default 16, meaning 32-bit words per message block sent to the core (2..32).
REQ-002 Parameter DIGEST_WORDS, default 8, meaning 32-bit words of digest returned by the core (1..8).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 address  in  4  Avalon-MM word address.
REQ-006 writedata  in  32  write data.
REQ-007 byteenable  in  4  byte lanes of writedata.
REQ-008 write, read, chipselect  in  1 each  Avalon-MM strobes; an access occurs only with chipselect=1.
REQ-009 readdata  out  32  registered read data.
REQ-010 blk_data  out  32*BLOCK_WORDS  message block to core; word i at [32*i+31:32*i].
REQ-011 blk_last, blk_valid  out  1 each  final-block flag, block-valid handshake.
REQ-012 blk_ready  in  1  core accepts block when blk_valid and blk_ready are both 1 at a rising edge.
REQ-013 dig_data  in  32*DIGEST_WORDS  digest from core; dig_valid  in  1  one-cycle digest strobe.

Function
REQ-014 Register map: 0x0..0x7 read digest word n (0 when n>=DIGEST_WORDS); 0x8 write DATA; 0x9 write CTRL; 0xA read STATUS; other addresses read 0, writes ignored.
REQ-015 readdata updates on the edge following a read access (1-cycle latency) and holds until the next read access.
REQ-016 STATUS = {16'b0, count[7:0], 4'b0, overflow, full, done, busy}.
REQ-017 FSM states FILL, ISSUE, WAIT_DIG, DONE; reset state FILL.
REQ-018 FILL: DATA write stores writedata into buffer word count and increments count; byte lanes with byteenable=0 stored as 0x00.
REQ-019 FILL: when count reaches BLOCK_WORDS, next state ISSUE with blk_last=0.
REQ-020 FILL: CTRL write with bit0 (LAST)=1 gives next state ISSUE with blk_last=1; unwritten words are zero.
REQ-021 Same-cycle DATA write filling the last slot cannot coincide with CTRL (single port); LAST with count=0 issues an all-zero final block.
REQ-022 ISSUE: blk_valid=1, blk_data and blk_last stable until the handshake; on handshake count clears and buffer zeroes; next state WAIT_DIG if blk_last else FILL.
REQ-023 WAIT_DIG: on dig_valid capture dig_data into digest registers, go to DONE; dig_valid in any other state is ignored.
REQ-024 DONE: digest readable, done=1; CTRL LAST ignored; first DATA write starts a new message (done clears, word stored as in FILL, state FILL).
REQ-025 DATA write when state is ISSUE or WAIT_DIG is dropped and sets sticky overflow.
REQ-026 CTRL bit1 (CLEAR)=1 in any state: state FILL, count 0, buffer zero, blk_valid 0, overflow 0, done 0; digest retained; CLEAR overrides LAST in the same write.
REQ-027 busy=1 in ISSUE and WAIT_DIG; full=1 when count=BLOCK_WORDS.

Reset
REQ-028 reset_n low asynchronously forces state FILL, count 0, buffer 0, digest 0, readdata 0, blk_valid 0, blk_last 0, flags 0; holds until the first rising edge after deassertion.
REQ-029 Reset mid-handshake drops blk_valid immediately; a later dig_valid is ignored.

Configuration
REQ-030 Macro HASH_FRONTEND_IRQ_EN defined: adds output irq (1 bit), set on entering DONE, cleared by any read of 0xA, by CLEAR, or by reset; STATUS bit4 mirrors irq.
REQ-031 Macro undefined: no irq port; STATUS bit4 reads 0; behaviour otherwise identical.

Verification
REQ-032 Reset, LAST with no data -> one handshake, blk_last=1, blk_data all zero; dig_valid with digest 0x01..0x08 per word -> read 0x0 returns 0x00000001 two cycles later.
REQ-033 Write DATA 0x00000008 then 0x80000000, CTRL=0x1 -> blk_data word0=0x00000008, word1=0x80000000, rest 0, blk_last=1; STATUS busy=1.
REQ-034 16 DATA writes 0x0..0xF with blk_ready=0 for 5 cycles -> blk_valid held, 17th write dropped, overflow=1; after handshake blk_last=0 and state FILL.
REQ-035 DATA 0xCCDDEEFF with byteenable=4'b0101 then LAST -> word0=0x00DD00FF.
REQ-036 CLEAR during WAIT_DIG then dig_valid -> digest unchanged, STATUS=0; with HASH_FRONTEND_IRQ_EN irq stays 0.
REQ-037 reset_n pulsed low while blk_valid=1 -> blk_valid falls without a clock edge; all reads return 0.
